// File: rtl/ysyx_22040750_pc_redirect_ctrl_if.sv
// Request/response bundle between the redirect sources, the controller and IF.
// Valid/ready rule: O_pc is taken by IF on a rising edge where O_pc_valid && I_pc_ready; O_pc, O_src and O_pc_valid stay put while a non-sequential redirect waits for I_pc_ready.
interface ysyx_22040750_pc_redirect_ctrl_if;
  logic        I_trap_valid;
  logic [31:0] I_trap_pc;
  logic        I_br_valid;
  logic [31:0] I_br_pc;
  logic        I_fence_valid;
  logic [31:0] I_fence_pc;
  logic        I_seq_valid;
  logic [31:0] I_seq_pc;
  logic        I_pc_ready;
  logic [31:0] O_pc;
  logic        O_pc_valid;
  logic [1:0]  O_src;
  logic        O_flush;
  logic        O_hold;
  logic [31:0] O_redirect_cnt;
  logic [1:0]  O_dbg_state;

  modport master (
    input  I_trap_valid, I_trap_pc, I_br_valid, I_br_pc,
    input  I_fence_valid, I_fence_pc, I_seq_valid, I_seq_pc, I_pc_ready,
    output O_pc, O_pc_valid, O_src, O_flush, O_hold, O_redirect_cnt, O_dbg_state
  );

  modport slave (
    output I_trap_valid, I_trap_pc, I_br_valid, I_br_pc,
    output I_fence_valid, I_fence_pc, I_seq_valid, I_seq_pc, I_pc_ready,
    input  O_pc, O_pc_valid, O_src, O_flush, O_hold, O_redirect_cnt, O_dbg_state
  );
endinterface

// File: rtl/ysyx_22040750_pc_redirect_ctrl.sv
// Next-PC arbiter in front of the fetch PC register: boot PC, then trap > br > fence > seq,
// with non-sequential redirects parked until IF accepts them.
module ysyx_22040750_pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC           = 32'h8000_0000,
  parameter bit          PRIO_TRAP_OVERRIDE = 1'b1
) (
  input logic I_clk,
  input logic I_rst_n,
  ysyx_22040750_pc_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] SRC_SEQ   = 2'd0;
  localparam logic [1:0] SRC_FENCE = 2'd1;
  localparam logic [1:0] SRC_BR    = 2'd2;
  localparam logic [1:0] SRC_TRAP  = 2'd3;

  state_t      state;
  logic [31:0] hold_pc;
  logic [1:0]  hold_src;
  logic [31:0] redirect_cnt;

  logic [31:0] run_pc;
  logic [1:0]  run_src;
  logic        run_any;
  logic        trap_override;
  logic [31:0] trap_pc_clr;

  logic [31:0] pc_c;
  logic [1:0]  src_c;
  logic        valid_c;
  logic        flush_c;
  logic        hold_c;

  assign trap_pc_clr   = {bus.I_trap_pc[31:1], 1'b0};
  assign trap_override = PRIO_TRAP_OVERRIDE && bus.I_trap_valid && (hold_src != SRC_TRAP);

  // Fixed-priority pick used only in RUN; bit 0 is cleared on every candidate.
  always_comb begin
    run_any = bus.I_trap_valid | bus.I_br_valid | bus.I_fence_valid | bus.I_seq_valid;
    run_pc  = {bus.I_seq_pc[31:1], 1'b0};
    run_src = SRC_SEQ;
    if (bus.I_trap_valid) begin
      run_pc  = trap_pc_clr;
      run_src = SRC_TRAP;
    end else if (bus.I_br_valid) begin
      run_pc  = {bus.I_br_pc[31:1], 1'b0};
      run_src = SRC_BR;
    end else if (bus.I_fence_valid) begin
      run_pc  = {bus.I_fence_pc[31:1], 1'b0};
      run_src = SRC_FENCE;
    end
  end

  always_comb begin
    pc_c    = {RESET_PC[31:1], 1'b0};
    src_c   = SRC_SEQ;
    valid_c = 1'b0;
    flush_c = 1'b0;
    hold_c  = 1'b0;
    case (state)
      ST_BOOT: begin
        valid_c = 1'b1;
      end
      ST_RUN: begin
        pc_c    = run_pc;
        src_c   = run_src;
        valid_c = run_any;
        flush_c = (run_src != SRC_SEQ);
      end
      ST_HOLD: begin
        valid_c = 1'b1;
        hold_c  = 1'b1;
        if (trap_override) begin
          pc_c    = trap_pc_clr;
          src_c   = SRC_TRAP;
          flush_c = 1'b1;
        end else begin
          pc_c  = hold_pc;
          src_c = hold_src;
        end
      end
      default: begin
        valid_c = 1'b0;
      end
    endcase
  end

  // Reset forces BOOT, whose PC/src are already the reset values; only valid needs gating.
  assign bus.O_pc           = pc_c;
  assign bus.O_src          = src_c;
  assign bus.O_pc_valid     = valid_c & I_rst_n;
  assign bus.O_flush        = flush_c;
  assign bus.O_hold         = hold_c;
  assign bus.O_redirect_cnt = redirect_cnt;
  assign bus.O_dbg_state    = state;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= ST_BOOT;
      hold_pc      <= 32'd0;
      hold_src     <= SRC_SEQ;
      redirect_cnt <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (bus.I_pc_ready) state <= ST_RUN;
        end
        ST_RUN: begin
          if (run_src != SRC_SEQ) begin
            if (bus.I_pc_ready) begin
              redirect_cnt <= redirect_cnt + 32'd1;
            end else begin
              hold_pc  <= run_pc;
              hold_src <= run_src;
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.I_pc_ready) begin
            redirect_cnt <= redirect_cnt + 32'd1;
            state        <= ST_RUN;
          end else if (trap_override) begin
            hold_pc  <= trap_pc_clr;
            hold_src <= SRC_TRAP;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_pc_redirect_ctrl.sv
// Bench for the PC redirect controller: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the redirect rules.
module tb_ysyx_22040750_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic I_clk;
  logic I_rst_n;

  ysyx_22040750_pc_redirect_ctrl_if bus ();

  ysyx_22040750_pc_redirect_ctrl #(
    .RESET_PC(RESET_PC),
    .PRIO_TRAP_OVERRIDE(1'b1)
  ) dut (
    .I_clk(I_clk),
    .I_rst_n(I_rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // ---------------- reference model ----------------
  // booted: boot PC already taken; pend_*: a redirect still owed to IF.
  bit          m_booted   = 1'b0;
  bit          m_pend     = 1'b0;
  logic [31:0] m_pend_pc  = 32'd0;
  int          m_pend_src = 0;
  logic [31:0] m_cnt      = 32'd0;

  logic [31:0] e_pc;
  int          e_src;
  bit          e_valid;
  bit          e_flush;
  bit          e_hold;

  function automatic logic [31:0] clr0(input logic [31:0] v);
    return v & 32'hFFFF_FFFE;
  endfunction

  // Requests indexed by their source code, so the winner is the highest valid index.
  task automatic model_expect();
    bit          vld[4];
    logic [31:0] pcs[4];
    int          win;
    vld[0] = bus.I_seq_valid;   pcs[0] = bus.I_seq_pc;
    vld[1] = bus.I_fence_valid; pcs[1] = bus.I_fence_pc;
    vld[2] = bus.I_br_valid;    pcs[2] = bus.I_br_pc;
    vld[3] = bus.I_trap_valid;  pcs[3] = bus.I_trap_pc;
    e_pc = RESET_PC; e_src = 0; e_valid = 0; e_flush = 0; e_hold = 0;
    if (!I_rst_n) return;
    if (!m_booted) begin
      e_valid = 1;
    end else if (m_pend) begin
      e_valid = 1;
      e_hold  = 1;
      if (vld[3] && m_pend_src != 3) begin
        e_pc = clr0(pcs[3]); e_src = 3; e_flush = 1;
      end else begin
        e_pc = m_pend_pc; e_src = m_pend_src;
      end
    end else begin
      win = -1;
      for (int i = 0; i < 4; i++) if (vld[i]) win = i;
      e_valid = (win >= 0);
      if (win >= 0) begin
        e_pc    = clr0(pcs[win]);
        e_src   = win;
        e_flush = (win > 0);
      end else begin
        e_pc = clr0(bus.I_seq_pc);
      end
    end
  endtask

  always @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      m_booted = 0; m_pend = 0; m_pend_pc = 0; m_pend_src = 0; m_cnt = 0;
    end else begin
      model_expect();
      if (!m_booted) begin
        if (bus.I_pc_ready) m_booted = 1;
      end else if (bus.I_pc_ready && e_src != 0) begin
        m_cnt  = m_cnt + 1;
        m_pend = 0;
      end else if (e_src != 0) begin
        m_pend     = 1;
        m_pend_pc  = e_pc;
        m_pend_src = e_src;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge I_clk) begin
    model_expect();
    chk("pc_valid", 32'(bus.O_pc_valid), 32'(e_valid));
    chk("flush", 32'(bus.O_flush), 32'(e_flush));
    chk("hold", 32'(bus.O_hold), 32'(e_hold));
    chk("redirect_cnt", bus.O_redirect_cnt, m_cnt);
    if (e_valid || !I_rst_n) begin
      chk("pc", bus.O_pc, e_pc);
      chk("src", 32'(bus.O_src), 32'(e_src));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.I_trap_valid = 0;  bus.I_trap_pc  = 0;
    bus.I_br_valid = 0;    bus.I_br_pc    = 0;
    bus.I_fence_valid = 0; bus.I_fence_pc = 0;
    bus.I_seq_valid = 0;   bus.I_seq_pc   = 0;
    bus.I_pc_ready = 0;
  endtask

  initial begin
    I_rst_n = 1'b0;
    idle_inputs();
    repeat (3) step();

    // Boot issue then sequential fetch.
    I_rst_n = 1; bus.I_seq_valid = 1; bus.I_seq_pc = 32'h8000_0004; bus.I_pc_ready = 1;
    @(negedge I_clk);
    chk("lit_boot_pc", bus.O_pc, 32'h8000_0000);
    chk("lit_boot_valid", 32'(bus.O_pc_valid), 32'd1);
    step(); @(negedge I_clk);
    chk("lit_seq_pc", bus.O_pc, 32'h8000_0004);

    // Branch beats seq; bit 0 cleared.
    step(); bus.I_br_valid = 1; bus.I_br_pc = 32'h8000_0101;
    @(negedge I_clk);
    chk("lit_br_pc", bus.O_pc, 32'h8000_0100);
    chk("lit_br_src", 32'(bus.O_src), 32'd2);
    chk("lit_br_flush", 32'(bus.O_flush), 32'd1);
    step(); bus.I_br_valid = 0;
    @(negedge I_clk);
    chk("lit_cnt1", bus.O_redirect_cnt, 32'd1);
    chk("lit_flush_drop", 32'(bus.O_flush), 32'd0);

    // Branch pulse while IF stalls three cycles.
    step(); bus.I_br_valid = 1; bus.I_br_pc = 32'h8000_0300; bus.I_pc_ready = 0;
    step(); bus.I_br_valid = 0;
    @(negedge I_clk);
    chk("lit_hold", 32'(bus.O_hold), 32'd1);
    chk("lit_hold_pc", bus.O_pc, 32'h8000_0300);
    chk("lit_hold_noflush", 32'(bus.O_flush), 32'd0);
    step(); step(); bus.I_pc_ready = 1;
    step();
    @(negedge I_clk);
    chk("lit_cnt2", bus.O_redirect_cnt, 32'd2);

    // Trap replaces a held branch; wrong-path requests ignored.
    bus.I_br_valid = 1; bus.I_br_pc = 32'h8000_0400; bus.I_pc_ready = 0;
    step(); bus.I_br_valid = 0; bus.I_trap_valid = 1; bus.I_trap_pc = 32'h8000_0200;
    @(negedge I_clk);
    chk("lit_trap_ovr_pc", bus.O_pc, 32'h8000_0200);
    chk("lit_trap_ovr_flush", 32'(bus.O_flush), 32'd1);
    step(); bus.I_trap_valid = 0; bus.I_fence_valid = 1; bus.I_fence_pc = 32'h8000_0500;
    bus.I_br_valid = 1; bus.I_br_pc = 32'h8000_0600;
    @(negedge I_clk);
    chk("lit_trap_held_src", 32'(bus.O_src), 32'd3);
    chk("lit_trap_held_noflush", 32'(bus.O_flush), 32'd0);
    step(); bus.I_pc_ready = 1;
    @(negedge I_clk);
    chk("lit_trap_accept_pc", bus.O_pc, 32'h8000_0200);
    step(); bus.I_fence_valid = 0; bus.I_br_valid = 0;
    @(negedge I_clk);
    chk("lit_cnt3", bus.O_redirect_cnt, 32'd3);

    // Simultaneous trap/br/fence.
    bus.I_trap_valid = 1; bus.I_trap_pc = 32'h8000_0800;
    bus.I_br_valid = 1; bus.I_fence_valid = 1;
    @(negedge I_clk);
    chk("lit_all_src", 32'(bus.O_src), 32'd3);
    step(); bus.I_trap_valid = 0; bus.I_br_valid = 0; bus.I_fence_valid = 0;

    // Reset in the middle of a hold discards the held redirect.
    step(); bus.I_br_valid = 1; bus.I_br_pc = 32'h8000_0700; bus.I_pc_ready = 0;
    step(); bus.I_br_valid = 0;
    step(); I_rst_n = 0;
    #1;
    chk("lit_rst_valid", 32'(bus.O_pc_valid), 32'd0);
    step(); I_rst_n = 1; bus.I_pc_ready = 1;
    @(negedge I_clk);
    chk("lit_reboot_pc", bus.O_pc, 32'h8000_0000);
    step();
    @(negedge I_clk);
    chk("lit_after_reboot_pc", bus.O_pc, 32'h8000_0004);
    chk("lit_after_reboot_cnt", bus.O_redirect_cnt, 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      I_rst_n           = ($urandom_range(0, 199) != 0);
      bus.I_trap_valid  = ($urandom_range(0, 11) == 0);
      bus.I_br_valid    = ($urandom_range(0, 5) == 0);
      bus.I_fence_valid = ($urandom_range(0, 9) == 0);
      bus.I_seq_valid   = ($urandom_range(0, 3) != 0);
      bus.I_trap_pc     = $urandom;
      bus.I_br_pc       = $urandom;
      bus.I_fence_pc    = $urandom;
      bus.I_seq_pc      = $urandom;
      bus.I_pc_ready    = ($urandom_range(0, 2) != 0);
    end
    step();
    @(negedge I_clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
